// File: rtl/srt_divider_gen_if.sv
// Request/result bundle for the parametrised SRT divider.
// The master drives operands and the start pulse; the slave returns results and status flags.
interface srt_divider_gen_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient_out;
    logic [WIDTH-1:0] remainder_out;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, quotient_out, remainder_out, div_by_zero, overflow
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, quotient_out, remainder_out, div_by_zero, overflow
    );
endinterface

// File: rtl/srt_divider_gen.sv
// Radix-2 SRT iterative divider, digit set {-1,0,+1}, signed or unsigned per operation.
// Fixed latency: LOAD, NORM, WIDTH x ITER, FIX, SIGN (divide-by-zero exits through ZERO).
module srt_divider_gen #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    srt_divider_gen_if.slave   bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int PW = WIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_NORM, S_ITER, S_FIX, S_SIGN, S_ZERO, S_DONE
    } state_t;

    function automatic logic [SW-1:0] lzc(input logic [WIDTH-1:0] v);
        logic [SW-1:0] n;
        logic          found;
        n     = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (found || v[i]) begin
                found = 1'b1;
            end else begin
                n = n + SW'(1);
            end
        end
        return n;
    endfunction

    state_t           r_state;
    logic             r_signed, r_n_neg, r_d_neg, r_ovf_pend;
    logic [WIDTH-1:0] r_dvd, r_dvs, r_n_mag, r_d_mag, r_d_norm, r_nsh;
    logic [WIDTH-1:0] r_qpos, r_qneg, r_q;
    logic [SW-1:0]    r_shift, r_cnt;
    logic [PW-1:0]    r_p;
    logic             r_busy, r_done, r_dbz, r_ovf;
    logic [WIDTH-1:0] r_quot, r_rem;

    logic [SW-1:0]      w_lz;
    logic [2*WIDTH-1:0] w_n_ext;
    logic [PW-1:0]      w_d_ext, w_p_sh, w_p_next, w_p_fix;
    logic [2:0]         w_top;
    logic               w_dpos, w_dneg, w_n_neg, w_d_neg;
    logic [WIDTH-1:0]   w_q_raw, w_q_fix, w_rem_mag;

    // Normalisation, digit selection and final correction datapath.
    always_comb begin
        w_n_neg = r_signed & r_dvd[WIDTH-1];
        w_d_neg = r_signed & r_dvs[WIDTH-1];
        w_lz    = lzc(r_d_mag);
        // Dividend is pre-scaled by the same shift so the quotient is unchanged.
        w_n_ext = {{WIDTH{1'b0}}, r_n_mag} << w_lz;
        w_d_ext = {2'b00, r_d_norm};
        w_p_sh  = {r_p[PW-2:0], r_nsh[WIDTH-1]};
        w_top   = w_p_sh[PW-1:PW-3];
        if (!w_top[2] && (w_top != 3'b000)) begin
            w_dpos   = 1'b1;
            w_dneg   = 1'b0;
            w_p_next = w_p_sh - w_d_ext;
        end else if (w_top[2] && (w_top != 3'b111)) begin
            w_dpos   = 1'b0;
            w_dneg   = 1'b1;
            w_p_next = w_p_sh + w_d_ext;
        end else begin
            w_dpos   = 1'b0;
            w_dneg   = 1'b0;
            w_p_next = w_p_sh;
        end
        w_q_raw = r_qpos - r_qneg;
        if (r_p[PW-1]) begin
            w_p_fix = r_p + w_d_ext;
            w_q_fix = w_q_raw - WIDTH'(1);
        end else begin
            w_p_fix = r_p;
            w_q_fix = w_q_raw;
        end
        w_rem_mag = r_p[WIDTH-1:0] >> r_shift;
    end

    // Control FSM and all result/status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_signed   <= 1'b0;
            r_n_neg    <= 1'b0;
            r_d_neg    <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_n_mag    <= '0;
            r_d_mag    <= '0;
            r_d_norm   <= '0;
            r_nsh      <= '0;
            r_qpos     <= '0;
            r_qneg     <= '0;
            r_q        <= '0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_p        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
            r_ovf      <= 1'b0;
            r_quot     <= '0;
            r_rem      <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_signed <= bus.signed_op;
                        r_dvd    <= bus.dividend;
                        r_dvs    <= bus.divisor;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_dbz    <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_n_neg    <= w_n_neg;
                    r_d_neg    <= w_d_neg;
                    r_n_mag    <= w_n_neg ? -r_dvd : r_dvd;
                    r_d_mag    <= w_d_neg ? -r_dvs : r_dvs;
                    r_ovf_pend <= r_signed && (r_dvd == {1'b1, {(WIDTH-1){1'b0}}})
                                  && (r_dvs == {WIDTH{1'b1}});
                    r_state    <= (r_dvs == '0) ? S_ZERO : S_NORM;
                end
                S_NORM: begin
                    r_d_norm <= r_d_mag << w_lz;
                    r_shift  <= w_lz;
                    r_p      <= {2'b00, w_n_ext[2*WIDTH-1:WIDTH]};
                    r_nsh    <= w_n_ext[WIDTH-1:0];
                    r_qpos   <= '0;
                    r_qneg   <= '0;
                    r_cnt    <= '0;
                    r_state  <= S_ITER;
                end
                S_ITER: begin
                    r_p    <= w_p_next;
                    r_nsh  <= {r_nsh[WIDTH-2:0], 1'b0};
                    r_qpos <= {r_qpos[WIDTH-2:0], w_dpos};
                    r_qneg <= {r_qneg[WIDTH-2:0], w_dneg};
                    r_cnt  <= r_cnt + SW'(1);
                    if (r_cnt == SW'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_p     <= w_p_fix;
                    r_q     <= w_q_fix;
                    r_state <= S_SIGN;
                end
                S_SIGN: begin
                    r_quot  <= (r_n_neg ^ r_d_neg) ? -r_q : r_q;
                    r_rem   <= r_n_neg ? -w_rem_mag : w_rem_mag;
                    r_ovf   <= r_ovf_pend;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_DONE;
                end
                S_ZERO: begin
                    r_quot  <= {WIDTH{1'b1}};
                    r_rem   <= r_dvd;
                    r_dbz   <= 1'b1;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.quotient_out  = r_quot;
    assign bus.remainder_out = r_rem;
    assign bus.div_by_zero   = r_dbz;
    assign bus.overflow      = r_ovf;
endmodule

// File: tb/tb_srt_divider_gen.sv
// Self-checking bench for srt_divider_gen at WIDTH 8, 16 and 4: directed table,
// control corner cases and randomised operations against an arithmetic reference model.
module tb_srt_divider_gen;
    logic        clk = 1'b0;
    logic        rst;
    int          sel;
    logic        tb_start, tb_sg;
    logic [15:0] tb_a, tb_b;
    int          n_pass, n_total;

    always #5 clk = ~clk;

    srt_divider_gen_if #(.WIDTH(8))  if8();
    srt_divider_gen_if #(.WIDTH(16)) if16();
    srt_divider_gen_if #(.WIDTH(4))  if4();

    srt_divider_gen #(.WIDTH(8))  u_div8  (.clk(clk), .rst(rst), .bus(if8));
    srt_divider_gen #(.WIDTH(16)) u_div16 (.clk(clk), .rst(rst), .bus(if16));
    srt_divider_gen #(.WIDTH(4))  u_div4  (.clk(clk), .rst(rst), .bus(if4));

    assign if8.start      = tb_start && (sel == 8);
    assign if8.signed_op  = tb_sg;
    assign if8.dividend   = tb_a[7:0];
    assign if8.divisor    = tb_b[7:0];
    assign if16.start     = tb_start && (sel == 16);
    assign if16.signed_op = tb_sg;
    assign if16.dividend  = tb_a;
    assign if16.divisor   = tb_b;
    assign if4.start      = tb_start && (sel == 4);
    assign if4.signed_op  = tb_sg;
    assign if4.dividend   = tb_a[3:0];
    assign if4.divisor    = tb_b[3:0];

    logic [31:0] o_q, o_r;
    logic        o_busy, o_done, o_dz, o_ov;

    always_comb begin
        o_q = 32'd0; o_r = 32'd0; o_busy = 1'b0; o_done = 1'b0; o_dz = 1'b0; o_ov = 1'b0;
        case (sel)
            8: begin
                o_q = {24'd0, if8.quotient_out}; o_r = {24'd0, if8.remainder_out};
                o_busy = if8.busy; o_done = if8.done; o_dz = if8.div_by_zero; o_ov = if8.overflow;
            end
            16: begin
                o_q = {16'd0, if16.quotient_out}; o_r = {16'd0, if16.remainder_out};
                o_busy = if16.busy; o_done = if16.done; o_dz = if16.div_by_zero; o_ov = if16.overflow;
            end
            4: begin
                o_q = {28'd0, if4.quotient_out}; o_r = {28'd0, if4.remainder_out};
                o_busy = if4.busy; o_done = if4.done; o_dz = if4.div_by_zero; o_ov = if4.overflow;
            end
            default: begin
                o_q = 32'd0;
            end
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s (W=%0d): actual=%0h required=%0h", name, sel, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic longint sx(input logic [31:0] v, input int w);
        longint m;
        m = (64'sd1 << w) - 64'sd1;
        if (v[w-1]) return (longint'(v) & m) - (64'sd1 << w);
        else return longint'(v) & m;
    endfunction

    // Reference: plain truncating division with the flag rules applied on top.
    task automatic model(input int w, input bit sg, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output logic ov, output int lat);
        longint m, sa, sb, ua, ub;
        m  = (64'sd1 << w) - 64'sd1;
        ua = longint'(a) & m;
        ub = longint'(b) & m;
        dz = 1'b0; ov = 1'b0; lat = w + 4;
        if (ub == 0) begin
            dz = 1'b1; q = 32'(m); r = 32'(ua); lat = 2;
        end else if (sg) begin
            sa = sx(a, w); sb = sx(b, w);
            if (sa == -(64'sd1 << (w - 1)) && sb == -64'sd1) begin
                ov = 1'b1; q = 32'(ua); r = 32'd0;
            end else begin
                q = 32'((sa / sb) & m); r = 32'((sa % sb) & m);
            end
        end else begin
            q = 32'(ua / ub); r = 32'(ua % ub);
        end
    endtask

    task automatic run_op(input int w, input bit sg, input logic [31:0] a, input logic [31:0] b,
                          input int glitch_at,
                          output logic [31:0] q, output logic [31:0] r,
                          output logic dz, output logic ov, output int lat);
        sel = w;
        @(negedge clk);
        tb_a = a[15:0]; tb_b = b[15:0]; tb_sg = sg; tb_start = 1'b1;
        @(posedge clk);
        #1;
        tb_start = 1'b0;
        tb_a = 16'($urandom); tb_b = 16'($urandom); tb_sg = 1'($urandom);
        chk("accept_busy", {31'd0, o_busy}, 32'd1);
        chk("accept_clr", {29'd0, o_done, o_dz, o_ov}, 32'd0);
        lat = 0;
        while (!o_done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            tb_start = (lat == glitch_at);
        end
        tb_start = 1'b0;
        q = o_q; r = o_r; dz = o_dz; ov = o_ov;
        chk("done_busy_low", {31'd0, o_busy}, 32'd0);
    endtask

    typedef struct {
        bit         sg;
        logic [7:0] a, b, q, r;
        bit         dz, ov;
    } vec_t;

    vec_t        vt[13];
    logic [31:0] q, r, eq, er;
    logic        dz, ov, edz, eov;
    int          lat, elat;
    int          widths[3];

    initial begin
        n_pass = 0; n_total = 0;
        sel = 8; tb_start = 1'b0; tb_sg = 1'b0; tb_a = 16'd0; tb_b = 16'd0;
        widths = '{8, 16, 4};
        vt[0]  = '{1'b1, 8'd100,  8'd5,   8'd20,  8'd0,   1'b0, 1'b0};
        vt[1]  = '{1'b1, 8'd25,   8'd3,   8'd8,   8'd1,   1'b0, 1'b0};
        vt[2]  = '{1'b1, 8'd0,    8'd5,   8'd0,   8'd0,   1'b0, 1'b0};
        vt[3]  = '{1'b1, 8'hE7,   8'd3,   8'hF8,  8'hFF,  1'b0, 1'b0};
        vt[4]  = '{1'b1, 8'd25,   8'hFD,  8'hF8,  8'd1,   1'b0, 1'b0};
        vt[5]  = '{1'b1, 8'hE7,   8'hFD,  8'd8,   8'hFF,  1'b0, 1'b0};
        vt[6]  = '{1'b1, 8'h80,   8'd7,   8'hEE,  8'hFE,  1'b0, 1'b0};
        vt[7]  = '{1'b0, 8'd200,  8'd7,   8'd28,  8'd4,   1'b0, 1'b0};
        vt[8]  = '{1'b0, 8'hFF,   8'd1,   8'hFF,  8'd0,   1'b0, 1'b0};
        vt[9]  = '{1'b0, 8'hFF,   8'hFF,  8'd1,   8'd0,   1'b0, 1'b0};
        vt[10] = '{1'b0, 8'h80,   8'h10,  8'd8,   8'd0,   1'b0, 1'b0};
        vt[11] = '{1'b1, 8'd37,   8'd0,   8'hFF,  8'd37,  1'b1, 1'b0};
        vt[12] = '{1'b1, 8'h80,   8'hFF,  8'h80,  8'd0,   1'b0, 1'b1};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        foreach (widths[k]) begin
            sel = widths[k];
            #1;
            chk("reset_q", o_q, 32'd0);
            chk("reset_r", o_r, 32'd0);
            chk("reset_flags", {28'd0, o_busy, o_done, o_dz, o_ov}, 32'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_op(8, vt[i].sg, {24'd0, vt[i].a}, {24'd0, vt[i].b}, -1, q, r, dz, ov, lat);
            chk($sformatf("vec%0d_q", i), q, {24'd0, vt[i].q});
            chk($sformatf("vec%0d_r", i), r, {24'd0, vt[i].r});
            chk($sformatf("vec%0d_dz", i), {31'd0, dz}, {31'd0, vt[i].dz});
            chk($sformatf("vec%0d_ov", i), {31'd0, ov}, {31'd0, vt[i].ov});
            chk($sformatf("vec%0d_lat", i), lat, vt[i].dz ? 32'd2 : 32'd12);
        end

        // Results hold while idle.
        repeat (3) @(posedge clk);
        #1;
        chk("hold_done", {31'd0, o_done}, 32'd1);
        chk("hold_q", o_q, 32'h80);
        chk("hold_ov", {31'd0, o_ov}, 32'd1);

        // Second start mid-ITER is ignored.
        run_op(8, 1'b1, 32'd100, 32'd5, 5, q, r, dz, ov, lat);
        chk("glitch_q", q, 32'd20);
        chk("glitch_r", r, 32'd0);
        chk("glitch_lat", lat, 32'd12);
        repeat (4) @(posedge clk);
        #1;
        chk("glitch_no_restart", {30'd0, o_busy, o_done}, 32'd1);

        // Reset mid-ITER discards the operation.
        sel = 8;
        @(negedge clk);
        tb_a = 16'd25; tb_b = 16'd3; tb_sg = 1'b1; tb_start = 1'b1;
        @(posedge clk);
        #1;
        tb_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_q", o_q, 32'd0);
        chk("rst_mid_r", o_r, 32'd0);
        chk("rst_mid_flags", {28'd0, o_busy, o_done, o_dz, o_ov}, 32'd0);
        run_op(8, 1'b1, 32'd81, 32'd9, -1, q, r, dz, ov, lat);
        chk("after_rst_q", q, 32'd9);
        chk("after_rst_r", r, 32'd0);
        chk("after_rst_lat", lat, 32'd12);

        // Randomised operations on every width.
        foreach (widths[k]) begin
            for (int i = 0; i < 40; i++) begin
                logic [31:0] a, b;
                bit          sg;
                int          w;
                w  = widths[k];
                sg = 1'($urandom);
                a  = $urandom;
                b  = $urandom;
                case ($urandom_range(0, 15))
                    0: b = 32'd0;
                    1: begin a = 32'd1 << (w - 1); b = 32'hFFFF_FFFF; sg = 1'b1; end
                    2: b = 32'd1;
                    default: b = b >> $urandom_range(0, w - 1);
                endcase
                model(w, sg, a, b, eq, er, edz, eov, elat);
                run_op(w, sg, a, b, -1, q, r, dz, ov, lat);
                chk($sformatf("rnd%0d_q", i), q, eq);
                chk($sformatf("rnd%0d_r", i), r, er);
                chk($sformatf("rnd%0d_flags", i), {30'd0, dz, ov}, {30'd0, edz, eov});
                chk($sformatf("rnd%0d_lat", i), lat, elat);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
